// File: rtl/micro_sequencer_if.sv
// Sequencer bus: micro-instruction fields in, micro-PC and status out.
// The controller side uses master, the sequencer uses slave.
interface micro_sequencer_if #(
  parameter int UPC_W = 7
);
  logic             stall;
  logic [2:0]       next_sel;
  logic [UPC_W-1:0] target;
  logic             cond;
  logic [UPC_W-1:0] dispatch_addr;
  logic             trap_req;
  logic [UPC_W-1:0] upc;
  logic [1:0]       depth;
  logic             inst_done;
  logic             seq_err;

  modport master (
    output stall, next_sel, target, cond, dispatch_addr, trap_req,
    input  upc, depth, inst_done, seq_err
  );

  modport slave (
    input  stall, next_sel, target, cond, dispatch_addr, trap_req,
    output upc, depth, inst_done, seq_err
  );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: picks the next micro-ROM address each cycle, with a
// 2-deep call stack, stall hold, trap redirection and a micro-step watchdog.
module micro_sequencer #(
  parameter int UPC_W      = 7,
  parameter int FETCH_ADDR = 0,
  parameter int TRAP_ADDR  = 2**UPC_W-1,
  parameter int WDOG_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  micro_sequencer_if.slave     bus
);

  localparam int CNT_W = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_LIMIT-1);
  localparam logic [UPC_W-1:0] FETCH_UPC = UPC_W'(FETCH_ADDR);
  localparam logic [UPC_W-1:0] TRAP_UPC  = UPC_W'(TRAP_ADDR);

  typedef enum logic [2:0] {
    SEL_SEQ      = 3'd0,
    SEL_JUMP     = 3'd1,
    SEL_COND     = 3'd2,
    SEL_DISPATCH = 3'd3,
    SEL_CALL     = 3'd4,
    SEL_RETURN   = 3'd5,
    SEL_FETCH    = 3'd6,
    SEL_RSVD     = 3'd7
  } sel_e;

  logic [UPC_W-1:0] r_upc;
  logic [1:0]       r_depth;
  logic [UPC_W-1:0] r_stack [2];
  logic [CNT_W-1:0] r_cnt;

  sel_e             w_sel;
  logic [UPC_W-1:0] w_upc_inc;
  logic [UPC_W-1:0] w_pop_val;
  logic             w_illegal;
  logic [UPC_W-1:0] w_upc_nxt;
  logic [1:0]       w_depth_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_push;
  logic             w_done;
  logic             w_err;

  assign w_sel     = sel_e'(bus.next_sel);
  assign w_upc_inc = r_upc + 1'b1;
  // Top of stack sits at depth-1: entry 1 when two frames are live.
  assign w_pop_val = r_stack[r_depth[1]];

  assign w_illegal = ((w_sel == SEL_CALL)   && r_depth[1])
                  || ((w_sel == SEL_RETURN) && (r_depth == 2'd0))
                  ||  (w_sel == SEL_RSVD)
                  || ((r_cnt == CNT_LAST)   && (w_sel != SEL_FETCH));

  always_comb begin
    w_upc_nxt   = r_upc;
    w_depth_nxt = r_depth;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (bus.trap_req) begin
      w_upc_nxt   = TRAP_UPC;
      w_depth_nxt = 2'd0;
      w_cnt_nxt   = '0;
    end else if (bus.stall) begin
      w_upc_nxt   = r_upc;
    end else if (w_illegal) begin
      w_upc_nxt   = TRAP_UPC;
      w_depth_nxt = 2'd0;
      w_cnt_nxt   = '0;
      w_err       = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
      case (w_sel)
        SEL_SEQ:      w_upc_nxt = w_upc_inc;
        SEL_JUMP:     w_upc_nxt = bus.target;
        SEL_COND:     w_upc_nxt = bus.cond ? bus.target : w_upc_inc;
        SEL_DISPATCH: w_upc_nxt = bus.dispatch_addr;
        SEL_CALL: begin
          w_upc_nxt   = bus.target;
          w_depth_nxt = r_depth + 2'd1;
          w_push      = 1'b1;
        end
        SEL_RETURN: begin
          w_upc_nxt   = w_pop_val;
          w_depth_nxt = r_depth - 2'd1;
        end
        SEL_FETCH: begin
          w_upc_nxt   = FETCH_UPC;
          w_depth_nxt = 2'd0;
          w_cnt_nxt   = '0;
          w_done      = 1'b1;
        end
        default: w_upc_nxt = r_upc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upc      <= FETCH_UPC;
      r_depth    <= 2'd0;
      r_cnt      <= '0;
      r_stack[0] <= '0;
      r_stack[1] <= '0;
    end else begin
      r_upc   <= w_upc_nxt;
      r_depth <= w_depth_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_push) r_stack[r_depth[0]] <= w_upc_inc;
    end
  end

  assign bus.upc       = r_upc;
  assign bus.depth     = r_depth;
  assign bus.inst_done = w_done;
  assign bus.seq_err   = w_err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a default instance plus a WDOG_LIMIT=4
// instance sharing the same stimulus.
module tb_micro_sequencer;

  localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, CND = 3'd2, DSP = 3'd3,
                         CAL = 3'd4, RET = 3'd5, FET = 3'd6, RSV = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic s_done, s_err, sb_done, sb_err;

  always #5 clk = ~clk;

  micro_sequencer_if #(.UPC_W(7)) a_if ();
  micro_sequencer_if #(.UPC_W(7)) b_if ();

  assign b_if.stall         = a_if.stall;
  assign b_if.next_sel      = a_if.next_sel;
  assign b_if.target        = a_if.target;
  assign b_if.cond          = a_if.cond;
  assign b_if.dispatch_addr = a_if.dispatch_addr;
  assign b_if.trap_req      = a_if.trap_req;

  micro_sequencer #(.UPC_W(7)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  micro_sequencer #(.UPC_W(7), .WDOG_LIMIT(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  // Drive one micro-instruction, capture pulses mid-cycle, end 1ns past the edge.
  task automatic cycle(input logic [2:0] sel, input logic [6:0] tgt, input logic c);
    a_if.next_sel = sel;
    a_if.target   = tgt;
    a_if.cond     = c;
    @(negedge clk);
    s_done  = a_if.inst_done;
    s_err   = a_if.seq_err;
    sb_done = b_if.inst_done;
    sb_err  = b_if.seq_err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_if.stall = 1'b0; a_if.trap_req = 1'b0; a_if.next_sel = SEQ;
    a_if.target = '0; a_if.cond = 1'b0; a_if.dispatch_addr = '0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++; if (a_if.upc !== 7'd0) begin n_err++; $display("FAIL rst_upc got %0d want 0", a_if.upc); end
    n_vec++; if (a_if.depth !== 2'd0) begin n_err++; $display("FAIL rst_depth got %0d want 0", a_if.depth); end
    n_vec++; if (a_if.inst_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", a_if.inst_done); end
    n_vec++; if (a_if.seq_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", a_if.seq_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_vec++; if (a_if.upc !== 7'd0) begin n_err++; $display("FAIL rst_release_upc got %0d want 0", a_if.upc); end
  endtask

  task automatic test_seq_fetch;
    for (int i = 1; i <= 3; i++) begin
      cycle(SEQ, 7'd0, 1'b0);
      n_vec++; if (a_if.upc !== 7'(i)) begin n_err++; $display("FAIL seq_upc got %0d want %0d", a_if.upc, i); end
      n_vec++; if (s_done !== 1'b0) begin n_err++; $display("FAIL seq_done got %b want 0", s_done); end
    end
    cycle(FET, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd0) begin n_err++; $display("FAIL fetch_upc got %0d want 0", a_if.upc); end
    n_vec++; if (s_done !== 1'b1) begin n_err++; $display("FAIL fetch_done got %b want 1", s_done); end
    cycle(SEQ, 7'd0, 1'b0);
    n_vec++; if (s_done !== 1'b0) begin n_err++; $display("FAIL done_pulse got %b want 0", s_done); end
  endtask

  task automatic test_wrap_cond;
    cycle(JMP, 7'd127, 1'b0);
    n_vec++; if (a_if.upc !== 7'd127) begin n_err++; $display("FAIL jump_upc got %0d want 127", a_if.upc); end
    cycle(SEQ, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd0) begin n_err++; $display("FAIL wrap_upc got %0d want 0", a_if.upc); end
    n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL wrap_err got %b want 0", s_err); end
    cycle(CND, 7'd40, 1'b0);
    n_vec++; if (a_if.upc !== 7'd1) begin n_err++; $display("FAIL cond0_upc got %0d want 1", a_if.upc); end
    cycle(CND, 7'd40, 1'b1);
    n_vec++; if (a_if.upc !== 7'd40) begin n_err++; $display("FAIL cond1_upc got %0d want 40", a_if.upc); end
    cycle(FET, 7'd0, 1'b0);
  endtask

  task automatic test_call_return;
    cycle(JMP, 7'd5, 1'b0);
    cycle(CAL, 7'd20, 1'b0);
    n_vec++; if (a_if.upc !== 7'd20 || a_if.depth !== 2'd1) begin n_err++; $display("FAIL call1 upc=%0d depth=%0d want 20/1", a_if.upc, a_if.depth); end
    cycle(SEQ, 7'd0, 1'b0);
    cycle(CAL, 7'd30, 1'b0);
    n_vec++; if (a_if.upc !== 7'd30 || a_if.depth !== 2'd2) begin n_err++; $display("FAIL call2 upc=%0d depth=%0d want 30/2", a_if.upc, a_if.depth); end
    cycle(RET, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd22 || a_if.depth !== 2'd1) begin n_err++; $display("FAIL ret1 upc=%0d depth=%0d want 22/1", a_if.upc, a_if.depth); end
    cycle(RET, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd6 || a_if.depth !== 2'd0) begin n_err++; $display("FAIL ret2 upc=%0d depth=%0d want 6/0", a_if.upc, a_if.depth); end
    n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL ret2_err got %b want 0", s_err); end
    cycle(CAL, 7'd20, 1'b0);
    cycle(CAL, 7'd30, 1'b0);
    cycle(CAL, 7'd40, 1'b0);
    n_vec++; if (a_if.upc !== 7'd127 || a_if.depth !== 2'd0) begin n_err++; $display("FAIL overflow upc=%0d depth=%0d want 127/0", a_if.upc, a_if.depth); end
    n_vec++; if (s_err !== 1'b1) begin n_err++; $display("FAIL overflow_err got %b want 1", s_err); end
  endtask

  task automatic test_errors;
    cycle(JMP, 7'd10, 1'b0);
    n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL err_pulse_clear got %b want 0", s_err); end
    cycle(RET, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd127 || s_err !== 1'b1) begin n_err++; $display("FAIL underflow upc=%0d err=%b want 127/1", a_if.upc, s_err); end
    cycle(JMP, 7'd10, 1'b0);
    cycle(RSV, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd127 || s_err !== 1'b1) begin n_err++; $display("FAIL reserved upc=%0d err=%b want 127/1", a_if.upc, s_err); end
    cycle(FET, 7'd0, 1'b0);
  endtask

  task automatic test_stall_trap;
    cycle(JMP, 7'd9, 1'b0);
    a_if.dispatch_addr = 7'h15;
    a_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(DSP, 7'd0, 1'b0);
      n_vec++; if (a_if.upc !== 7'd9 || s_err !== 1'b0) begin n_err++; $display("FAIL stall_hold upc=%0d err=%b want 9/0", a_if.upc, s_err); end
    end
    cycle(FET, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd9 || s_done !== 1'b0) begin n_err++; $display("FAIL stall_fetch upc=%0d done=%b want 9/0", a_if.upc, s_done); end
    a_if.stall = 1'b0;
    cycle(DSP, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'h15) begin n_err++; $display("FAIL dispatch got %0h want 15", a_if.upc); end
    cycle(CAL, 7'd50, 1'b0);
    a_if.stall = 1'b1;
    cycle(RET, 7'd0, 1'b0);
    cycle(RET, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd50 || a_if.depth !== 2'd1) begin n_err++; $display("FAIL stall_ret upc=%0d depth=%0d want 50/1", a_if.upc, a_if.depth); end
    a_if.stall = 1'b0;
    cycle(RET, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'h16 || a_if.depth !== 2'd0) begin n_err++; $display("FAIL unstall_ret upc=%0h depth=%0d want 16/0", a_if.upc, a_if.depth); end
    cycle(CAL, 7'd60, 1'b0);
    a_if.stall = 1'b1; a_if.trap_req = 1'b1;
    cycle(SEQ, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd127 || a_if.depth !== 2'd0 || s_err !== 1'b0) begin n_err++; $display("FAIL trap upc=%0d depth=%0d err=%b want 127/0/0", a_if.upc, a_if.depth, s_err); end
    a_if.stall = 1'b0; a_if.trap_req = 1'b0;
    cycle(FET, 7'd0, 1'b0);
  endtask

  task automatic test_watchdog;
    cycle(FET, 7'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle(SEQ, 7'd0, 1'b0);
      n_vec++; if (b_if.upc !== 7'(i) || sb_err !== 1'b0) begin n_err++; $display("FAIL wdog_seq upc=%0d err=%b want %0d/0", b_if.upc, sb_err, i); end
    end
    cycle(SEQ, 7'd0, 1'b0);
    n_vec++; if (b_if.upc !== 7'd127 || sb_err !== 1'b1) begin n_err++; $display("FAIL wdog_expire upc=%0d err=%b want 127/1", b_if.upc, sb_err); end
    n_vec++; if (a_if.upc !== 7'd4 || s_err !== 1'b0) begin n_err++; $display("FAIL wdog_big upc=%0d err=%b want 4/0", a_if.upc, s_err); end
    cycle(FET, 7'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(SEQ, 7'd0, 1'b0);
    cycle(FET, 7'd0, 1'b0);
    n_vec++; if (b_if.upc !== 7'd0 || sb_done !== 1'b1 || sb_err !== 1'b0) begin n_err++; $display("FAIL wdog_last_fetch upc=%0d done=%b err=%b want 0/1/0", b_if.upc, sb_done, sb_err); end
  endtask

  task automatic test_async_reset;
    cycle(CAL, 7'd20, 1'b0);
    n_vec++; if (a_if.depth !== 2'd1) begin n_err++; $display("FAIL pre_reset depth got %0d want 1", a_if.depth); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (a_if.upc !== 7'd0 || a_if.depth !== 2'd0) begin n_err++; $display("FAIL async_reset upc=%0d depth=%0d want 0/0", a_if.upc, a_if.depth); end
    n_vec++; if (a_if.seq_err !== 1'b0) begin n_err++; $display("FAIL async_reset_err got %b want 0", a_if.seq_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(RET, 7'd0, 1'b0);
    n_vec++; if (a_if.upc !== 7'd127 || s_err !== 1'b1) begin n_err++; $display("FAIL post_reset_ret upc=%0d err=%b want 127/1", a_if.upc, s_err); end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_wrap_cond();
    test_call_return();
    test_errors();
    test_stall_trap();
    test_watchdog();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
